// File: rtl/uart_flash_loader_if.sv
// Flash bus bundle between uart_flash_loader (master) and the flash controller (slave).
interface uart_flash_loader_if;
  logic [31:0] fl_addr_o;
  logic [31:0] fl_data_o;
  logic [31:0] fl_data_i;
  logic        fl_select_o;
  logic        fl_we_o;
  logic        fl_ack_i;

  modport master (
    output fl_addr_o, fl_data_o, fl_select_o, fl_we_o,
    input  fl_data_i, fl_ack_i
  );

  modport slave (
    input  fl_addr_o, fl_data_o, fl_select_o, fl_we_o,
    output fl_data_i, fl_ack_i
  );
endinterface

// File: rtl/uart_flash_loader.sv
// Command engine: turns UART byte frames into flash read/write bus transactions
// and streams the ACK/NAK/read-data response back through the UART transmitter.
module uart_flash_loader #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BYTE_TIMEOUT = 500_000,
  parameter int ACK_TIMEOUT  = 1_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  uart_flash_loader_if.master        fl,
  output logic                       busy,
  output logic [7:0]                 frame_cnt,
  output logic [7:0]                 err_cnt
);
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam int clk_hz_unused = CLK_HZ;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_DATA1, S_DATA0, S_BUS, S_TX, S_TX_GUARD
  } state_e;

  state_e          state_q, state_d;
  logic            cmd_w_q, cmd_w_d;
  logic [22:0]     addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic [1:0][7:0] resp_q, resp_d;
  logic [1:0]      resp_cnt_q, resp_cnt_d;
  logic            resp_nak_q, resp_nak_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            sel_q, busy_q;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            err_inc;

  // Only the low half of the read word carries data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^fl.fl_data_i[31:16];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cmd_w_d     = cmd_w_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_d      = resp_q;
    resp_cnt_d  = resp_cnt_q;
    resp_nak_d  = resp_nak_q;
    byte_cnt_d  = byte_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        ack_cnt_d  = '0;
        if (rx_valid) begin
          if (rx_data == CMD_R || rx_data == CMD_W) begin
            cmd_w_d = (rx_data == CMD_W);
            state_d = S_ADDR2;
          end else begin
            resp_d[0]  = RSP_NAK;
            resp_cnt_d = 2'd1;
            resp_nak_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = S_TX;
          end
        end
      end
      S_ADDR2, S_ADDR1, S_ADDR0, S_DATA1, S_DATA0: begin
        // A byte arriving on the timeout cycle still wins.
        if (rx_valid) begin
          byte_cnt_d = '0;
          case (state_q)
            S_ADDR2: begin addr_d = {addr_q[14:0], rx_data}; state_d = S_ADDR1; end
            S_ADDR1: begin addr_d = {addr_q[14:0], rx_data}; state_d = S_ADDR0; end
            S_ADDR0: begin
              addr_d  = {addr_q[14:0], rx_data};
              state_d = cmd_w_q ? S_DATA1 : S_BUS;
            end
            S_DATA1: begin data_d = {data_q[7:0], rx_data}; state_d = S_DATA0; end
            default: begin data_d = {data_q[7:0], rx_data}; state_d = S_BUS; end
          endcase
        end else if (byte_cnt_q == BYTE_LAST) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + BW'(1);
        end
      end
      S_BUS: begin
        if (fl.fl_ack_i) begin
          resp_nak_d = 1'b0;
          if (cmd_w_q) begin
            resp_d[0]  = RSP_ACK;
            resp_cnt_d = 2'd1;
          end else begin
            resp_d[0]  = fl.fl_data_i[15:8];
            resp_d[1]  = fl.fl_data_i[7:0];
            resp_cnt_d = 2'd2;
          end
          state_d = S_TX;
        end else if (ack_cnt_q == ACK_LAST) begin
          resp_d[0]  = RSP_NAK;
          resp_cnt_d = 2'd1;
          resp_nak_d = 1'b1;
          err_inc    = 1'b1;
          state_d    = S_TX;
        end else begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
      end
      S_TX: begin
        if (!tx_busy) begin
          if (resp_cnt_q != 2'd0) begin
            tx_start_d = 1'b1;
            tx_data_d  = resp_q[0];
            resp_d[0]  = resp_q[1];
            resp_cnt_d = resp_cnt_q - 2'd1;
            state_d    = S_TX_GUARD;
          end else begin
            if (!resp_nak_q) frame_cnt_d = frame_cnt_q + 8'd1;
            state_d = S_IDLE;
          end
        end
      end
      S_TX_GUARD: state_d = S_TX;
      default:    state_d = S_IDLE;
    endcase

    if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_w_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      resp_cnt_q  <= '0;
      resp_nak_q  <= 1'b0;
      byte_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_w_q     <= cmd_w_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_q      <= resp_d;
      resp_cnt_q  <= resp_cnt_d;
      resp_nak_q  <= resp_nak_d;
      byte_cnt_q  <= byte_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      sel_q       <= (state_d == S_BUS);
      busy_q      <= (state_d != S_IDLE);
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_start       = tx_start_q;
  assign fl.fl_addr_o   = {9'b0, addr_q};
  assign fl.fl_data_o   = {16'b0, data_q};
  assign fl.fl_select_o = sel_q;
  assign fl.fl_we_o     = cmd_w_q;
  assign busy           = busy_q;
  assign frame_cnt      = frame_cnt_q;
  assign err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_uart_flash_loader.sv
// Randomised bench for uart_flash_loader: flash and UART-TX models plus a frame-level
// reference model of expected responses and counters.
module tb_uart_flash_loader;
  localparam int BYTE_TO = 40;
  localparam int ACK_TO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic [7:0] frame_cnt, err_cnt;

  uart_flash_loader_if fl_if ();

  uart_flash_loader #(
    .CLK_HZ(50_000_000), .BYTE_TIMEOUT(BYTE_TO), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .fl(fl_if), .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference-model state
  logic [7:0] exp_frame = 8'd0;
  logic [7:0] exp_err = 8'd0;

  // UART transmitter model
  logic [7:0] tx_q[$];
  int busy_len = 2;
  int busy_left = 0;
  int last_tx_cyc = -10;
  bit tx_pend = 1'b0;

  // Flash model
  int ack_delay = 3;
  logic [15:0] rd_val = 16'h0000;
  int sel_cycles = 0;
  int last_sel_len = 0;
  int n_txn = 0;
  int unstable = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_data = '0;
  logic cap_we = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic busy_seen;
    if (rst) begin
      tx_busy = 1'b0;
      tx_pend = 1'b0;
      busy_left = 0;
      last_tx_cyc = -10;
    end else begin
      busy_seen = tx_busy;
      if (tx_pend) begin
        tx_busy = 1'b1;
        busy_left = busy_len;
        tx_pend = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (tx_start === 1'b1) begin
        checks++;
        if (busy_seen !== 1'b0 || (cyc - last_tx_cyc) < 2) begin
          failures++;
          $display("FAIL tx_spacing: tx_busy=%b gap=%0d, required tx_busy=0 gap>=2",
                   busy_seen, cyc - last_tx_cyc);
        end
        tx_q.push_back(tx_data);
        last_tx_cyc = cyc;
        tx_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      fl_if.fl_ack_i = 1'b0;
      fl_if.fl_data_i = '0;
      sel_cycles = 0;
    end else begin
      fl_if.fl_ack_i = 1'b0;
      fl_if.fl_data_i = {16'hA5C3, rd_val};
      if (fl_if.fl_select_o === 1'b1) begin
        sel_cycles++;
        if (sel_cycles == 1) begin
          cap_addr = fl_if.fl_addr_o;
          cap_data = fl_if.fl_data_o;
          cap_we = fl_if.fl_we_o;
          n_txn++;
        end else if (fl_if.fl_addr_o !== cap_addr || fl_if.fl_data_o !== cap_data ||
                     fl_if.fl_we_o !== cap_we) begin
          unstable++;
        end
        if (ack_delay >= 0 && sel_cycles == ack_delay + 1) fl_if.fl_ack_i = 1'b1;
      end else if (sel_cycles != 0) begin
        last_sel_len = sel_cycles;
        sel_cycles = 0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_frame = 8'd0;
    exp_err = 8'd0;
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_wait: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [23:0] a, input logic [15:0] d,
                           input logic [15:0] rd, input int ack_d, input int gap_min,
                           input int gap_max, input string tag);
    logic [7:0] bytes[$];
    logic [7:0] exp_rsp[$];
    int txn0;
    bit is_w, is_r;
    is_w = (cmd == 8'h57);
    is_r = (cmd == 8'h52);
    ack_delay = ack_d;
    rd_val = rd;
    tx_q.delete();
    txn0 = n_txn;
    bytes.push_back(cmd);
    if (is_r || is_w) begin
      bytes.push_back(a[23:16]);
      bytes.push_back(a[15:8]);
      bytes.push_back(a[7:0]);
    end
    if (is_w) begin
      bytes.push_back(d[15:8]);
      bytes.push_back(d[7:0]);
    end
    foreach (bytes[i]) begin
      if (i > 0) repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
      send_byte(bytes[i]);
    end
    wait_idle(400, tag);

    if (!(is_r || is_w) || ack_d < 0 || ack_d >= ACK_TO) begin
      exp_rsp.push_back(8'h15);
      if (exp_err != 8'hFF) exp_err++;
    end else begin
      if (is_r) begin
        exp_rsp.push_back(rd[15:8]);
        exp_rsp.push_back(rd[7:0]);
      end else begin
        exp_rsp.push_back(8'h06);
      end
      exp_frame++;
    end

    checks++;
    if (tx_q.size() !== exp_rsp.size()) begin
      failures++;
      $display("FAIL %s rsp_len: got %0d bytes, expected %0d", tag, tx_q.size(), exp_rsp.size());
    end
    foreach (exp_rsp[i]) begin
      if (i < tx_q.size()) begin
        checks++;
        if (tx_q[i] !== exp_rsp[i]) begin
          failures++;
          $display("FAIL %s rsp_byte%0d: got %h, expected %h", tag, i, tx_q[i], exp_rsp[i]);
        end
      end
    end
    checks++;
    if (frame_cnt !== exp_frame || err_cnt !== exp_err) begin
      failures++;
      $display("FAIL %s counters: frame_cnt=%0d err_cnt=%0d, expected %0d %0d",
               tag, frame_cnt, err_cnt, exp_frame, exp_err);
    end
    checks++;
    if (is_r || is_w) begin
      if (n_txn - txn0 !== 1 || cap_addr !== {9'b0, a[22:0]} || cap_we !== is_w ||
          (is_w && cap_data !== {16'b0, d}) || unstable !== 0) begin
        failures++;
        $display("FAIL %s bus: txns=%0d addr=%h data=%h we=%b unstable=%0d, expected 1 %h %h %b 0",
                 tag, n_txn - txn0, cap_addr, cap_data, cap_we, unstable,
                 {9'b0, a[22:0]}, {16'b0, d}, is_w);
      end
    end else if (n_txn !== txn0) begin
      failures++;
      $display("FAIL %s bus: %0d transactions for a bad command, expected 0", tag, n_txn - txn0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h, expected 00", tx_data); end
    if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start: got %b, expected 0", tx_start); end
    if (fl_if.fl_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h, expected 0", fl_if.fl_addr_o); end
    if (fl_if.fl_data_o !== 32'h0) begin failures++; $display("FAIL rst_data: got %h, expected 0", fl_if.fl_data_o); end
    if (fl_if.fl_select_o !== 1'b0) begin failures++; $display("FAIL rst_select: got %b, expected 0", fl_if.fl_select_o); end
    if (fl_if.fl_we_o !== 1'b0) begin failures++; $display("FAIL rst_we: got %b, expected 0", fl_if.fl_we_o); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (frame_cnt !== 8'd0) begin failures++; $display("FAIL rst_frame_cnt: got %0d, expected 0", frame_cnt); end
    if (err_cnt !== 8'd0) begin failures++; $display("FAIL rst_err_cnt: got %0d, expected 0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    apply_reset();
    busy_len = 2;
    run_frame(8'h57, 24'h001234, 16'hABCD, 16'h0000, 3, 0, 0, "write");
    checks++;
    if (cap_addr !== 32'h00001234 || cap_data !== 32'h0000ABCD || cap_we !== 1'b1 ||
        frame_cnt !== 8'd1 || tx_q.size() != 1) begin
      failures++;
      $display("FAIL write_directed: addr=%h data=%h we=%b frame_cnt=%0d rsp_len=%0d, expected 00001234 0000abcd 1 1 1",
               cap_addr, cap_data, cap_we, frame_cnt, tx_q.size());
    end
  endtask

  task automatic test_read();
    busy_len = 5;
    run_frame(8'h52, 24'h800010, 16'h0000, 16'hBEEF, 3, 0, 0, "read");
    checks++;
    if (cap_addr !== 32'h00000010 || cap_we !== 1'b0 || tx_q.size() != 2) begin
      failures++;
      $display("FAIL read_directed: addr=%h we=%b rsp_len=%0d, expected 00000010 0 2",
               cap_addr, cap_we, tx_q.size());
    end else begin
      checks++;
      if (tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF) begin
        failures++;
        $display("FAIL read_bytes: got %h %h, expected be ef", tx_q[0], tx_q[1]);
      end
    end
  endtask

  task automatic test_bad_and_ack_timeout();
    apply_reset();
    busy_len = 2;
    run_frame(8'h41, 24'h0, 16'h0, 16'h0, 3, 0, 0, "bad_cmd");
    run_frame(8'h52, 24'h345678, 16'h0, 16'h1234, -1, 0, 0, "ack_timeout");
    checks++;
    if (last_sel_len !== ACK_TO || err_cnt !== 8'd2 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL ack_timeout_len: select=%0d err_cnt=%0d frame_cnt=%0d, expected %0d 2 0",
               last_sel_len, err_cnt, frame_cnt, ACK_TO);
    end
    run_frame(8'h57, 24'h0ABCDE, 16'h5AA5, 16'h0, ACK_TO - 1, 0, 0, "ack_at_timeout");
  endtask

  task automatic test_byte_timeout();
    int n = 0;
    apply_reset();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    while (busy !== 1'b0 && n < BYTE_TO + 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== BYTE_TO || tx_q.size() != 0 || err_cnt !== 8'd1 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL byte_timeout: idle after %0d cycles, tx=%0d err_cnt=%0d frame_cnt=%0d, expected %0d 0 1 0",
               n, tx_q.size(), err_cnt, frame_cnt, BYTE_TO);
    end
    exp_err = 8'd1;
    run_frame(8'h52, 24'h012345, 16'h0, 16'hC0DE, 2, 0, 0, "after_timeout");
    run_frame(8'h57, 24'h7FFFFF, 16'h1357, 16'h0, 1, BYTE_TO - 1, BYTE_TO - 1, "gap_at_limit");
  endtask

  task automatic test_rx_during_tx();
    int n = 0;
    logic [15:0] rd;
    rd = 16'($urandom);
    busy_len = 8;
    ack_delay = 4;
    rd_val = rd;
    tx_q.delete();
    send_byte(8'h52);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h57);
    while (tx_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    send_byte(8'h52);
    send_byte(8'h57);
    send_byte(8'h41);
    wait_idle(200, "rx_in_tx");
    exp_frame++;
    checks++;
    if (tx_q.size() != 2 || frame_cnt !== exp_frame || err_cnt !== exp_err) begin
      failures++;
      $display("FAIL rx_in_tx: rsp_len=%0d frame_cnt=%0d err_cnt=%0d, expected 2 %0d %0d",
               tx_q.size(), frame_cnt, err_cnt, exp_frame, exp_err);
    end else begin
      checks++;
      if (tx_q[0] !== rd[15:8] || tx_q[1] !== rd[7:0]) begin
        failures++;
        $display("FAIL rx_in_tx_bytes: got %h %h, expected %h %h", tx_q[0], tx_q[1], rd[15:8], rd[7:0]);
      end
    end
    busy_len = 2;
    run_frame(8'h57, 24'h00BEEF, 16'hFACE, 16'h0, 0, 0, 1, "after_rx_in_tx");
  endtask

  task automatic test_reset_mid_bus();
    ack_delay = -1;
    tx_q.delete();
    send_byte(8'h52);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    checks++;
    if (fl_if.fl_select_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_bus_select: got %b, expected 1", fl_if.fl_select_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_data, tx_start, fl_if.fl_addr_o, fl_if.fl_data_o, fl_if.fl_select_o,
         fl_if.fl_we_o, busy, frame_cnt, err_cnt} !== '0) begin
      failures++;
      $display("FAIL mid_bus_reset: tx_data=%h tx_start=%b addr=%h data=%h sel=%b we=%b busy=%b fc=%0d ec=%0d, expected all 0",
               tx_data, tx_start, fl_if.fl_addr_o, fl_if.fl_data_o, fl_if.fl_select_o,
               fl_if.fl_we_o, busy, frame_cnt, err_cnt);
    end
    rst = 1'b0;
    exp_frame = 8'd0;
    exp_err = 8'd0;
    repeat (ACK_TO + 5) @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_bus_no_rsp: tx=%0d busy=%b, expected 0 0", tx_q.size(), busy);
    end
    run_frame(8'h52, 24'h222222, 16'h0, 16'h4321, 2, 0, 0, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] cmd;
      int sel;
      int ackd;
      sel = $urandom_range(9);
      if (sel == 0) begin
        cmd = 8'($urandom);
        while (cmd == 8'h52 || cmd == 8'h57) cmd = 8'($urandom);
      end else begin
        cmd = (sel < 5) ? 8'h52 : 8'h57;
      end
      ackd = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(6));
      busy_len = $urandom_range(6, 1);
      run_frame(cmd, 24'($urandom), 16'($urandom), 16'($urandom), ackd, 0, 3, "random");
    end
  endtask

  task automatic test_err_saturate();
    apply_reset();
    busy_len = 1;
    for (int k = 0; k < 260; k++) run_frame(8'h00, 24'h0, 16'h0, 16'h0, 0, 0, 0, "err_sat");
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL err_saturate: got %0d, expected 255", err_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    busy_len = 1;
    for (int k = 0; k < 256; k++) begin
      run_frame(8'h57, 24'($urandom), 16'($urandom), 16'h0, 0, 0, 0, "wrap");
      if (k == 254) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255: got %0d, expected 255", frame_cnt);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL wrap_0: got %0d, expected 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_and_ack_timeout();
    test_byte_timeout();
    test_rx_during_tx();
    test_reset_mid_bus();
    test_random();
    test_err_saturate();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
